// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared stall state encoding and counter width default
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        IWAIT = 2'b01,
        DWAIT = 2'b10,
        HALT  = 2'b11
    } stallState_t;

    localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/stall_ctrl_strobe.sv
// rtl/stall_ctrl_strobe.sv - combinational state/event to pipeline strobe decode
module stall_ctrl_strobe
    import pipe_ctrl_pkg::*;
(
    input  logic        rst,
    input  stallState_t state,
    input  logic        redirPend,
    input  logic        iPend,
    input  logic        hazStall,
    input  logic        brTaken,
    input  logic        iMemStall,
    input  logic        iMemDone,
    input  logic        dMemStall,
    input  logic        dMemDone,
    input  logic        wbHalt,
    output logic        pcEn,
    output logic        pcRedirect,
    output logic        ifIdEn,
    output logic        idExEn,
    output logic        exMemEn,
    output logic        memWbEn,
    output logic        ifIdFlush,
    output logic        idExFlush,
    output logic        memWbFlush,
    output logic        halted
);

    // Strobe decode: start from free-running pipe, then apply the active stall/redirect rule
    always_comb begin
        pcEn       = 1'b1;
        pcRedirect = 1'b0;
        ifIdEn     = 1'b1;
        idExEn     = 1'b1;
        exMemEn    = 1'b1;
        memWbEn    = 1'b1;
        ifIdFlush  = 1'b0;
        idExFlush  = 1'b0;
        memWbFlush = 1'b0;
        halted     = 1'b0;
        if (rst) begin
            pcEn       = 1'b0;
            ifIdEn     = 1'b0;
            idExEn     = 1'b0;
            exMemEn    = 1'b0;
            memWbEn    = 1'b0;
            ifIdFlush  = 1'b1;
            idExFlush  = 1'b1;
            memWbFlush = 1'b1;
        end else begin
            unique case (state)
                RUN: begin
                    if (wbHalt) begin
                        pcEn    = 1'b0;
                        ifIdEn  = 1'b0;
                        idExEn  = 1'b0;
                        exMemEn = 1'b0;
                        memWbEn = 1'b0;
                    end else if (dMemStall) begin
                        // Freeze everything upstream of MEM; a taken branch stays in EX
                        pcEn       = 1'b0;
                        ifIdEn     = 1'b0;
                        idExEn     = 1'b0;
                        exMemEn    = 1'b0;
                        memWbFlush = 1'b1;
                    end else if (brTaken) begin
                        pcRedirect = 1'b1;
                        ifIdFlush  = 1'b1;
                        idExFlush  = 1'b1;
                    end else if (iMemStall) begin
                        pcEn      = 1'b0;
                        ifIdFlush = 1'b1;
                    end else if (hazStall) begin
                        pcEn      = 1'b0;
                        ifIdEn    = 1'b0;
                        idExFlush = 1'b1;
                    end
                end
                IWAIT: begin
                    if (dMemStall) begin
                        pcEn       = 1'b0;
                        ifIdEn     = 1'b0;
                        idExEn     = 1'b0;
                        exMemEn    = 1'b0;
                        memWbFlush = 1'b1;
                    end else begin
                        pcEn      = 1'b0;
                        ifIdFlush = 1'b1;
                        idExFlush = brTaken;
                        if (iMemDone) begin
                            // Fetch returned: either restart at the pending target or accept it
                            pcEn = 1'b1;
                            if (redirPend || brTaken) begin
                                pcRedirect = 1'b1;
                            end else begin
                                ifIdFlush = 1'b0;
                            end
                        end
                    end
                end
                DWAIT: begin
                    if (dMemDone) begin
                        if (iPend) begin
                            pcEn      = 1'b0;
                            ifIdFlush = 1'b1;
                        end
                    end else begin
                        pcEn       = 1'b0;
                        ifIdEn     = 1'b0;
                        idExEn     = 1'b0;
                        exMemEn    = 1'b0;
                        memWbFlush = 1'b1;
                    end
                end
                HALT: begin
                    pcEn    = 1'b0;
                    ifIdEn  = 1'b0;
                    idExEn  = 1'b0;
                    exMemEn = 1'b0;
                    memWbEn = 1'b0;
                    halted  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/stall_ctrl.sv
// rtl/stall_ctrl.sv - pipeline stall FSM, pending flags and stall counter (STALL_CTRL_STALL_CNT_EN)
module stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazStall,
    input  logic             brTaken,
    input  logic             iMemStall,
    input  logic             iMemDone,
    input  logic             dMemStall,
    input  logic             dMemDone,
    input  logic             wbHalt,
    output logic             pcEn,
    output logic             pcRedirect,
    output logic             ifIdEn,
    output logic             idExEn,
    output logic             exMemEn,
    output logic             memWbEn,
    output logic             ifIdFlush,
    output logic             idExFlush,
    output logic             memWbFlush,
    output logic             halted,
    output logic [CNT_W-1:0] stallCnt
);

    stallState_t state;
    stallState_t stateNext;
    logic        redirPend;
    logic        redirPendNext;
    logic        iPend;
    logic        iPendNext;

    stall_ctrl_strobe uStrobe (
        .rst        (rst),
        .state      (state),
        .redirPend  (redirPend),
        .iPend      (iPend),
        .hazStall   (hazStall),
        .brTaken    (brTaken),
        .iMemStall  (iMemStall),
        .iMemDone   (iMemDone),
        .dMemStall  (dMemStall),
        .dMemDone   (dMemDone),
        .wbHalt     (wbHalt),
        .pcEn       (pcEn),
        .pcRedirect (pcRedirect),
        .ifIdEn     (ifIdEn),
        .idExEn     (idExEn),
        .exMemEn    (exMemEn),
        .memWbEn    (memWbEn),
        .ifIdFlush  (ifIdFlush),
        .idExFlush  (idExFlush),
        .memWbFlush (memWbFlush),
        .halted     (halted)
    );

    // State and pending-flag registers; reset drops any outstanding redirect or fetch wait
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            redirPend <= 1'b0;
            iPend     <= 1'b0;
        end else begin
            state     <= stateNext;
            redirPend <= redirPendNext;
            iPend     <= iPendNext;
        end
    end

    // Next-state and pending-flag updates, same event priority as the strobe decode
    always_comb begin
        stateNext     = state;
        redirPendNext = redirPend;
        iPendNext     = iPend;
        unique case (state)
            RUN: begin
                if (wbHalt) begin
                    stateNext = HALT;
                end else if (dMemStall) begin
                    stateNext = DWAIT;
                end else if (brTaken) begin
                    if (iMemStall) begin
                        redirPendNext = 1'b1;
                        stateNext     = IWAIT;
                    end
                end else if (iMemStall) begin
                    stateNext = IWAIT;
                end
            end
            IWAIT: begin
                if (dMemStall) begin
                    iPendNext = 1'b1;
                    stateNext = DWAIT;
                end else if (iMemDone) begin
                    redirPendNext = 1'b0;
                    stateNext     = RUN;
                end else if (brTaken) begin
                    redirPendNext = 1'b1;
                end
            end
            DWAIT: begin
                if (dMemDone) begin
                    iPendNext = 1'b0;
                    stateNext = iPend ? IWAIT : RUN;
                end
            end
            HALT: stateNext = HALT;
            default: stateNext = RUN;
        endcase
    end

`ifdef STALL_CTRL_STALL_CNT_EN
    logic [CNT_W-1:0] cntQ;

    // Saturating count of cycles the PC was held outside HALT
    always_ff @(posedge clk) begin
        if (rst) begin
            cntQ <= '0;
        end else if (!pcEn && state != HALT && cntQ != {CNT_W{1'b1}}) begin
            cntQ <= cntQ + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stallCnt = cntQ;
`else
    assign stallCnt = '0;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// tb/tb_stall_ctrl.sv - directed self-checking bench for stall_ctrl
module tb_stall_ctrl;

    localparam int CW = 4;

    // Strobe vector: pcEn pcRedirect ifIdEn idExEn exMemEn memWbEn ifIdFlush idExFlush memWbFlush halted
    localparam logic [9:0] S_RST  = 10'b0_0_0000_111_0;
    localparam logic [9:0] S_RUN  = 10'b1_0_1111_000_0;
    localparam logic [9:0] S_HENT = 10'b0_0_0000_000_0;
    localparam logic [9:0] S_HALT = 10'b0_0_0000_000_1;
    localparam logic [9:0] S_DW   = 10'b0_0_0001_001_0;
    localparam logic [9:0] S_BR   = 10'b1_1_1111_110_0;
    localparam logic [9:0] S_IW   = 10'b0_0_1111_100_0;
    localparam logic [9:0] S_IWBR = 10'b0_0_1111_110_0;
    localparam logic [9:0] S_HAZ  = 10'b0_0_0111_010_0;
    localparam logic [9:0] S_IDR  = 10'b1_1_1111_100_0;

    // Event vector: hazStall brTaken iMemStall iMemDone dMemStall dMemDone wbHalt
    localparam logic [6:0] E_NONE = 7'b0000000;
    localparam logic [6:0] E_HAZ  = 7'b1000000;
    localparam logic [6:0] E_BR   = 7'b0100000;
    localparam logic [6:0] E_IS   = 7'b0010000;
    localparam logic [6:0] E_ID   = 7'b0001000;
    localparam logic [6:0] E_DS   = 7'b0000100;
    localparam logic [6:0] E_DD   = 7'b0000010;
    localparam logic [6:0] E_HLT  = 7'b0000001;

    logic clk = 1'b0;
    logic rst;
    logic hazStall, brTaken, iMemStall, iMemDone, dMemStall, dMemDone, wbHalt;
    logic pcEn, pcRedirect, ifIdEn, idExEn, exMemEn, memWbEn;
    logic ifIdFlush, idExFlush, memWbFlush, halted;
    logic [CW-1:0] stallCnt;

    int errors = 0;
    int checks = 0;
    logic [CW-1:0] expCnt = '0;
    logic [9:0] obs;

    always #5 clk = ~clk;

    stall_ctrl #(.CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .hazStall   (hazStall),
        .brTaken    (brTaken),
        .iMemStall  (iMemStall),
        .iMemDone   (iMemDone),
        .dMemStall  (dMemStall),
        .dMemDone   (dMemDone),
        .wbHalt     (wbHalt),
        .pcEn       (pcEn),
        .pcRedirect (pcRedirect),
        .ifIdEn     (ifIdEn),
        .idExEn     (idExEn),
        .exMemEn    (exMemEn),
        .memWbEn    (memWbEn),
        .ifIdFlush  (ifIdFlush),
        .idExFlush  (idExFlush),
        .memWbFlush (memWbFlush),
        .halted     (halted),
        .stallCnt   (stallCnt)
    );

    task automatic checkCnt(input string tag);
        logic [CW-1:0] want;
`ifdef STALL_CTRL_STALL_CNT_EN
        want = expCnt;
`else
        want = '0;
`endif
        checks++;
        assert (stallCnt === want) else begin
            errors++;
            $error("FAIL %s stallCnt observed=%0d expected=%0d", tag, stallCnt, want);
        end
    endtask

    // One cycle: drive events, check strobes mid-cycle, then check the counter after the edge
    task automatic step(input string tag, input logic rIn, input logic [6:0] ev, input logic [9:0] exp);
        rst = rIn;
        {hazStall, brTaken, iMemStall, iMemDone, dMemStall, dMemDone, wbHalt} = ev;
        @(negedge clk);
        obs = {pcEn, pcRedirect, ifIdEn, idExEn, exMemEn, memWbEn,
               ifIdFlush, idExFlush, memWbFlush, halted};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s strobes observed=%b expected=%b", tag, obs, exp);
        end
        @(posedge clk);
        if (rIn) expCnt = '0;
        else if (!exp[9] && !exp[0] && expCnt != {CW{1'b1}}) expCnt = expCnt + 1'b1;
        #1;
        checkCnt(tag);
    endtask

    initial begin
        rst = 1'b1;
        {hazStall, brTaken, iMemStall, iMemDone, dMemStall, dMemDone, wbHalt} = E_NONE;
        @(posedge clk);
        #1;

        step("reset0", 1'b1, E_NONE, S_RST);
        step("reset1", 1'b1, E_NONE, S_RST);
        step("run0",   1'b0, E_NONE, S_RUN);

        step("haz",     1'b0, E_HAZ,  S_HAZ);
        step("hazIdle", 1'b0, E_NONE, S_RUN);

        step("dStall",  1'b0, E_DS,   S_DW);
        step("dWait1",  1'b0, E_NONE, S_DW);
        step("dWait2",  1'b0, E_NONE, S_DW);
        step("dDone",   1'b0, E_DD,   S_RUN);
        step("dIdle",   1'b0, E_NONE, S_RUN);

        step("iStall",   1'b0, E_IS,   S_IW);
        step("iwBr",     1'b0, E_BR,   S_IWBR);
        step("iwIdle",   1'b0, E_NONE, S_IW);
        step("iDoneRed", 1'b0, E_ID,   S_IDR);
        step("iRedIdle", 1'b0, E_NONE, S_RUN);
        step("iStall2",  1'b0, E_IS,   S_IW);
        step("iDonePln", 1'b0, E_ID,   S_RUN);
        step("iPlnIdle", 1'b0, E_NONE, S_RUN);

        step("nIStall", 1'b0, E_IS,   S_IW);
        step("nDStall", 1'b0, E_DS,   S_DW);
        step("nDWait",  1'b0, E_NONE, S_DW);
        step("nDDone",  1'b0, E_DD,   S_IW);
        step("nIWait",  1'b0, E_NONE, S_IW);
        step("nIDone",  1'b0, E_ID,   S_RUN);
        step("nIdle",   1'b0, E_NONE, S_RUN);

        step("brIs",     1'b0, E_BR | E_IS, S_BR);
        step("brIsDone", 1'b0, E_ID,        S_IDR);
        step("brIsIdle", 1'b0, E_NONE,      S_RUN);

        step("dsBr",     1'b0, E_DS | E_BR, S_DW);
        step("ddDs",     1'b0, E_DD | E_DS, S_RUN);
        step("ddDsIdle", 1'b0, E_NONE,      S_RUN);

        step("dsH",      1'b0, E_DS,  S_DW);
        step("dwHalt",   1'b0, E_HLT, S_DW);
        step("dwHDone",  1'b0, E_DD,  S_RUN);
        step("dwHIdle",  1'b0, E_NONE, S_RUN);

        step("rBrIs",    1'b0, E_BR | E_IS, S_BR);
        step("rMid",     1'b1, E_NONE,      S_RST);
        step("rIStall",  1'b0, E_IS,        S_IW);
        step("rIDone",   1'b0, E_ID,        S_RUN);
        step("rIdle",    1'b0, E_NONE,      S_RUN);

        for (int i = 0; i < 20; i++) step("satHaz", 1'b0, E_HAZ, S_HAZ);
        step("satIdle", 1'b0, E_NONE, S_RUN);

        step("haltEnter", 1'b0, E_HLT, S_HENT);
        for (int i = 0; i < 10; i++) step("haltRand", 1'b0, 7'($urandom), S_HALT);

        step("haltRst",  1'b1, E_NONE, S_RST);
        step("postRst",  1'b0, E_NONE, S_RUN);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stall_ctrl.md
Name: stall_ctrl

Overview:
- Consumer side of the hazard unit's stall request. Converts load-use stalls, taken-branch redirects, instruction/data memory busy handshakes and halt into per-stage enable/flush strobes for the five pipeline latches (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Owns the only stall state machine in the core. Datapath latches obey its outputs unconditionally.

Parameters:
- CNT_W, 16, width of stall-cycle counter (optional feature).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- hazStall  in  1  load-use stall request from hazard unit (decode stage)
- brTaken  in  1  branch/jump resolved taken in EX this cycle
- iMemStall  in  1  instruction memory busy (fetch not valid)
- iMemDone  in  1  instruction memory returns fetch this cycle
- dMemStall  in  1  data memory busy on MEM-stage access
- dMemDone  in  1  data memory completes access this cycle
- wbHalt  in  1  HALT instruction in WB
- pcEn  out  1  PC register load
- pcRedirect  out  1  PC mux selects branch target (meaningful only with pcEn=1)
- ifIdEn, idExEn, exMemEn, memWbEn  out  1 each  latch load enables
- ifIdFlush, idExFlush, memWbFlush  out  1 each  load NOP instead of input (meaningful only with matching En=1)
- halted  out  1  core stopped
- stallCnt  out  CNT_W  total stall cycles (zero when feature absent)

Behaviour:
- States: RUN, IWAIT, DWAIT, HALT. Registers: state, redirPend, iPend, stallCnt.
- While rst=1, outputs are forced regardless of state: all En=0, all Flush=1, pcRedirect=0, halted=0. The next clk edge sets state=RUN, redirPend=0, iPend=0, stallCnt=0.
- Outputs are combinational from state and inputs. State updates at the clk edge.
- Default strobe set (RUN, no events): all En=1, all Flush=0, pcRedirect=0.
- RUN events, evaluated in priority order:
  1. wbHalt: all En=0 → HALT.
  2. dMemStall: pcEn, ifIdEn, idExEn, exMemEn=0; memWbEn=1 with memWbFlush=1 → DWAIT. If brTaken is also asserted, the branch is held in EX and resolves again after the stall; redirPend is not set.
  3. brTaken: pcEn=1, pcRedirect=1, ifIdFlush=1, idExFlush=1. Overrides hazStall and iMemStall this cycle. If iMemStall=1, set redirPend and go → IWAIT.
  4. iMemStall: pcEn=0, ifIdEn=1 with ifIdFlush=1; downstream advances → IWAIT.
  5. hazStall: pcEn=0, ifIdEn=0, idExEn=1 with idExFlush=1; downstream advances; stay RUN.
- IWAIT:
  - Each cycle: pcEn=0, ifIdFlush=1, downstream advances.
  - brTaken sets redirPend, asserts idExFlush, and leaves pcEn=0.
  - dMemStall: apply the DWAIT strobe, set iPend=1 → DWAIT.
  - iMemDone: if redirPend, assert pcEn=1 with pcRedirect=1 and ifIdFlush=1, then clear redirPend. Otherwise pcEn=1, ifIdEn=1 with no flush. Then → RUN.
- DWAIT:
  - Hold the DWAIT strobe until dMemDone.
  - In the dMemDone cycle: all En=1, no flush. If iPend=1, pcEn=0 and ifIdFlush=1; clear iPend; → IWAIT. Otherwise → RUN.
  - wbHalt is ignored while in DWAIT, because MEM/WB holds a bubble.
- HALT: all En=0, halted=1, until rst. All inputs are ignored.
- Simultaneous dMemDone and dMemStall: dMemDone wins; a new stall is only honoured in the following cycle.
- Reset asserted mid-IWAIT or mid-DWAIT discards redirPend and iPend.

Optional Feature:
- Macro STALL_CTRL_STALL_CNT_EN.
- When defined: stallCnt increments by 1 on every non-reset cycle in which pcEn=0 and state≠HALT. It saturates at all-ones and never wraps.
- When undefined: the counter logic is removed and stallCnt is tied to 0.

Decomposition:
- Shared package pipe_ctrl_pkg holds the state encoding constants (RUN=2'b00, IWAIT=2'b01, DWAIT=2'b10, HALT=2'b11) and the CNT_W default.
- One sub-module, stall_ctrl_strobe: purely combinational state/input → strobe decode.
- State registers, pending flags and the counter stay in stall_ctrl.

Test Plan:
- Reset: rst=1 for 2 cycles → all En=0, all Flush=1, halted=0. First cycle after release with no events → all En=1, stallCnt=0.
- Load-use: hazStall=1 for 1 cycle in RUN → pcEn=0, ifIdEn=0, idExFlush=1 that cycle; stays RUN. stallCnt=1 with the feature enabled.
- Data stall: dMemStall=1, dMemDone asserted 3 cycles later → 3 cycles of pcEn..exMemEn=0 with memWbFlush=1, then a release cycle with all En=1, then RUN.
- Branch during fetch stall: iMemStall=1, brTaken=1 next cycle, iMemDone 2 cycles later → pcRedirect=1 only in the iMemDone cycle, with ifIdFlush=1; redirPend then cleared.
- Nested stalls: IWAIT, then dMemStall → DWAIT; dMemDone → IWAIT with pcEn=0; iMemDone → RUN.
- Halt/saturation: wbHalt=1 → halted=1 and all En=0 through 10 cycles of random inputs. With CNT_W=4 and 20 stall cycles → stallCnt=4'hF.
